// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multicycle control FSM that sequences the processor datapath
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   opcode            : IR[31:26], sampled in DECOD and held for the rest of the instruction
//   zero, mem_pronto  : ULA zero flag, memory ready handshake
//   origALU, opALU    : ULA operand-B select and operation
//   regDst, memParaReg, escreveReg : register-file write path
//   leMem, escreveMem : memory read/write requests
//   escreveIR, escrevePC, origPC   : IR load, PC load and PC source
//   erro              : one-cycle pulse on memory timeout or illegal opcode
//   estado            : current state for debug
module controle_multiciclo #(
    parameter int TIMEOUT_MEM = 15,
    parameter int LARG_CONT   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_pronto,
    output logic       origALU,
    output logic [1:0] opALU,
    output logic       regDst,
    output logic       memParaReg,
    output logic       escreveReg,
    output logic       leMem,
    output logic       escreveMem,
    output logic       escreveIR,
    output logic       escrevePC,
    output logic [1:0] origPC,
    output logic       erro,
    output logic [2:0] estado
);
    typedef enum logic [2:0] {OCIOSO, BUSCA, DECOD, EXEC, MEM, ESCRITA, PARADO, INVALIDO} estado_t;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010, OP_HALT = 6'b111111;
    // the timeout fires on the wait cycle that would bring the count up to TIMEOUT_MEM
    localparam logic [LARG_CONT-1:0] LIMITE = LARG_CONT'(TIMEOUT_MEM - 1);
    estado_t st, st_next;
    logic [LARG_CONT-1:0] cont, cont_next;
    logic [5:0] op;
    logic esperando, expira;
    assign estado    = st;
    assign esperando = (st == BUSCA || st == MEM) && !mem_pronto;
    assign expira    = esperando && cont >= LIMITE;
    // counting only continues while waiting in the same memory state; any exit, ready or timeout clears it
    assign cont_next = (esperando && !expira && st_next == st) ? ((cont == '1) ? cont : cont + LARG_CONT'(1)) : '0;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            st   <= OCIOSO;
            cont <= '0;
            op   <= '0;
        end else begin
            st   <= st_next;
            cont <= cont_next;
            if (st == DECOD) op <= opcode;
        end
    end
    always_comb begin
        st_next    = st;
        origALU    = 1'b0;
        opALU      = 2'b00;
        regDst     = 1'b0;
        memParaReg = 1'b0;
        escreveReg = 1'b0;
        leMem      = 1'b0;
        escreveMem = 1'b0;
        escreveIR  = 1'b0;
        escrevePC  = 1'b0;
        origPC     = 2'b00;
        erro       = 1'b0;
        case (st)
            OCIOSO: st_next = BUSCA;
            BUSCA: begin
                leMem     = 1'b1;
                escreveIR = mem_pronto;
                escrevePC = mem_pronto;
                erro      = expira;
                st_next   = mem_pronto ? DECOD : BUSCA;
            end
            DECOD: begin
                case (opcode)
                    OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: st_next = EXEC;
                    OP_HALT: st_next = PARADO;
                    default: begin
                        erro    = 1'b1;
                        st_next = BUSCA;
                    end
                endcase
            end
            EXEC: begin
                case (op)
                    OP_R: begin
                        opALU   = 2'b10;
                        st_next = ESCRITA;
                    end
                    OP_ADDI: begin
                        origALU = 1'b1;
                        st_next = ESCRITA;
                    end
                    OP_LW, OP_SW: begin
                        origALU = 1'b1;
                        st_next = MEM;
                    end
                    OP_BEQ: begin
                        opALU     = 2'b01;
                        origPC    = 2'b01;
                        escrevePC = zero;
                        st_next   = BUSCA;
                    end
                    default: begin
                        origPC    = 2'b10;
                        escrevePC = 1'b1;
                        st_next   = BUSCA;
                    end
                endcase
            end
            MEM: begin
                origALU    = 1'b1;
                leMem      = op == OP_LW;
                escreveMem = op == OP_SW;
                erro       = expira;
                st_next    = mem_pronto ? ((op == OP_LW) ? ESCRITA : BUSCA) : (expira ? BUSCA : MEM);
            end
            ESCRITA: begin
                escreveReg = 1'b1;
                regDst     = op == OP_R;
                memParaReg = op == OP_LW;
                st_next    = BUSCA;
            end
            PARADO: st_next = PARADO;
            default: st_next = BUSCA;
        endcase
    end
endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: randomized scoreboard bench for controle_multiciclo
module tb_controle_multiciclo;
    localparam int TMO = 15;
    logic clock = 1'b0, reset = 1'b1, zero = 1'b0, mem_pronto = 1'b0;
    logic [5:0] opcode = '0;
    logic origALU, regDst, memParaReg, escreveReg, leMem, escreveMem, escreveIR, escrevePC, erro;
    logic [1:0] opALU, origPC;
    logic [2:0] estado;
    int tests = 0, fails = 0;
    logic [15:0] fila[$];

    controle_multiciclo #(.TIMEOUT_MEM(TMO), .LARG_CONT(8)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero), .mem_pronto(mem_pronto),
        .origALU(origALU), .opALU(opALU), .regDst(regDst), .memParaReg(memParaReg),
        .escreveReg(escreveReg), .leMem(leMem), .escreveMem(escreveMem), .escreveIR(escreveIR),
        .escrevePC(escrevePC), .origPC(origPC), .erro(erro), .estado(estado)
    );

    always #5 clock = ~clock;

    // vector layout: estado, origALU, opALU, regDst, memParaReg, escreveReg, leMem, escreveMem, escreveIR, escrevePC, origPC, erro
    function automatic logic [15:0] pk(logic [2:0] st, logic oa, logic [1:0] alu, logic rd, logic mr, logic er,
                                       logic lm, logic em, logic ei, logic ep, logic [1:0] pc, logic err);
        return {st, oa, alu, rd, mr, er, lm, em, ei, ep, pc, err};
    endfunction

    function automatic logic [15:0] atual();
        return pk(estado, origALU, opALU, regDst, memParaReg, escreveReg, leMem, escreveMem, escreveIR, escrevePC, origPC, erro);
    endfunction

    task automatic check(string nome, logic [15:0] got, logic [15:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", nome, got, want, $time);
        end
    endtask

    always @(negedge clock) begin
        if (fila.size() > 0) check("cycle", atual(), fila.pop_front());
    end

    // entered at posedge+1: drive this cycle's mem_pronto, record what the cycle must show, advance
    task automatic step(logic mp, logic [15:0] ev);
        mem_pronto = mp;
        fila.push_back(ev);
        @(posedge clock);
        #1;
    endtask

    task automatic run_instr(logic [5:0] op, logic z, int fw, int mw);
        bit r, lw, sw, beq, addi, j;
        r = op == 6'b000000; lw = op == 6'b100011; sw = op == 6'b101011;
        beq = op == 6'b000100; addi = op == 6'b001000; j = op == 6'b000010;
        opcode = op;
        zero = z;
        for (int w = 1; w <= fw; w++) step(1'b0, pk(3'd1, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, 2'b00, (w % TMO) == 0));
        step(1'b1, pk(3'd1, 0, 2'b00, 0, 0, 0, 1, 0, 1, 1, 2'b00, 0));
        if (op == 6'b111111) begin
            step(1'($urandom), pk(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
            for (int k = 0; k < 20; k++) begin
                opcode = 6'($urandom);
                step(1'($urandom), pk(3'd6, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
            end
            return;
        end
        if (!(r || lw || sw || beq || addi || j)) begin
            step(1'($urandom), pk(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1));
            return;
        end
        step(1'($urandom), pk(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
        opcode = 6'($urandom);
        if (beq) begin
            step(1'($urandom), pk(3'd3, 0, 2'b01, 0, 0, 0, 0, 0, 0, z, 2'b01, 0));
            return;
        end
        if (j) begin
            step(1'($urandom), pk(3'd3, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0));
            return;
        end
        step(1'($urandom), pk(3'd3, !r, r ? 2'b10 : 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
        if (lw || sw) begin
            for (int w = 1; w <= mw; w++) begin
                if (w == TMO) begin
                    step(1'b0, pk(3'd4, 1, 2'b00, 0, 0, 0, lw, sw, 0, 0, 2'b00, 1));
                    return;
                end
                step(1'b0, pk(3'd4, 1, 2'b00, 0, 0, 0, lw, sw, 0, 0, 2'b00, 0));
            end
            step(1'b1, pk(3'd4, 1, 2'b00, 0, 0, 0, lw, sw, 0, 0, 2'b00, 0));
            if (sw) return;
        end
        step(1'($urandom), pk(3'd5, 0, 2'b00, r, lw, 1, 0, 0, 0, 0, 2'b00, 0));
    endtask

    logic [5:0] legais[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

    initial begin
        logic [5:0] op;
        repeat (2) @(posedge clock);
        #1;
        check("reset_outputs", atual(), 16'h0000);
        reset = 1'b0;
        step(1'b0, 16'h0000);
        run_instr(6'b000000, 0, 0, 0);
        run_instr(6'b100011, 0, 0, 3);
        run_instr(6'b000100, 1, 0, 0);
        run_instr(6'b000100, 0, 0, 0);
        run_instr(6'b000000, 0, 31, 0);
        run_instr(6'b001000, 0, 14, 0);
        run_instr(6'b010101, 0, 0, 0);
        run_instr(6'b000010, 0, 0, 0);
        run_instr(6'b101011, 0, 0, 0);
        run_instr(6'b100011, 0, 0, 15);
        run_instr(6'b101011, 1, 2, 14);
        for (int n = 0; n < 60; n++) begin
            int idx;
            idx = $urandom_range(0, 6);
            if (idx < 6) op = legais[idx];
            else begin
                do op = 6'($urandom); while (op inside {legais, 6'b111111});
            end
            run_instr(op, 1'($urandom), ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3),
                      ($urandom_range(0, 7) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 3));
        end
        opcode = 6'b101011;
        step(1'b1, pk(3'd1, 0, 2'b00, 0, 0, 0, 1, 0, 1, 1, 2'b00, 0));
        step(1'b0, pk(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
        step(1'b0, pk(3'd3, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
        mem_pronto = 1'b0;
        fila.push_back(pk(3'd4, 1, 2'b00, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0));
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_mid_mem", atual(), 16'h0000);
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(1'b0, 16'h0000);
        run_instr(6'b000000, 0, 1, 0);
        run_instr(6'b111111, 0, 0, 0);
        @(negedge clock);
        #1;
        tests++;
        if (fila.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", fila.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
Multicycle control FSM that sequences the processor datapath. It drives the ULA operand-B select (origALU) and the ULA operation code, and it controls register-file write, memory read/write, IR and PC load. It sits between the instruction register opcode field, the ULA zero flag and the memory ready handshake on one side, and the datapath muxes and write enables on the other.

Parameters:
TIMEOUT_MEM, 15, maximum number of cycles to wait for mem_pronto in BUSCA or MEM before aborting. Range 1..255.
LARG_CONT, 8, width of the wait counter. Must hold TIMEOUT_MEM.

Ports:
clock  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high; clears state and outputs immediately
opcode  input  6  instruction bits [31:26] from the IR
zero  input  1  ULA zero flag
mem_pronto  input  1  memory ready; completes the current read or write in the same cycle
origALU  output  1  ULA operand-B select: 0 = rt data, 1 = immediate
opALU  output  2  ULA op: 00 = add, 01 = sub, 10 = decode from funct
regDst  output  1  destination register: 0 = rt, 1 = rd
memParaReg  output  1  write-back source: 0 = ULA, 1 = memory
escreveReg  output  1  register-file write enable
leMem  output  1  memory read request
escreveMem  output  1  memory write request
escreveIR  output  1  IR load
escrevePC  output  1  PC load
origPC  output  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target
erro  output  1  one-cycle pulse on timeout or illegal opcode
estado  output  3  current state, for debug

Behaviour:
- States: OCIOSO=0, BUSCA=1, DECOD=2, EXEC=3, MEM=4, ESCRITA=5, PARADO=6. The value 7 is unreachable; if entered, go to BUSCA.
- Reset (asynchronous, any time, including mid-memory-wait): state = OCIOSO, counter = 0, every output = 0.
- OCIOSO: all outputs 0. Go to BUSCA on the next edge.
- BUSCA: leMem=1.
  - If mem_pronto=1, then escreveIR=1, escrevePC=1, origPC=00 (all combinational, same cycle) and the next state is DECOD.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_MEM, pulse erro, clear the counter and stay in BUSCA (retry).
- DECOD: no enables. Next state by opcode:
  - 000000 (R), 100011 (lw), 101011 (sw), 000100 (beq), 001000 (addi), 000010 (j): go to EXEC.
  - 111111 (halt): go to PARADO.
  - Any other opcode: erro=1 for one cycle, go to BUSCA.
- EXEC:
  - R: origALU=0, opALU=10, then ESCRITA.
  - addi, lw, sw: origALU=1, opALU=00. addi goes to ESCRITA; lw and sw go to MEM.
  - beq: origALU=0, opALU=01, origPC=01, escrevePC=zero (combinational), then BUSCA.
  - j: origPC=10, escrevePC=1, then BUSCA.
- MEM: lw asserts leMem=1; sw asserts escreveMem=1. origALU and opALU are held at their EXEC values.
  - When mem_pronto=1: lw goes to ESCRITA, sw goes to BUSCA.
  - Timeout: pulse erro, go to BUSCA, no register write.
- ESCRITA: escreveReg=1 for exactly one cycle, then BUSCA.
  - R: regDst=1, memParaReg=0.
  - addi: regDst=0, memParaReg=0.
  - lw: regDst=0, memParaReg=1.
- PARADO: all outputs 0. Absorbing until reset.
- Counter handling:
  - Cleared on entry to BUSCA and MEM and on every mem_pronto.
  - Saturates and does not wrap.
  - If mem_pronto arrives in the same cycle the counter reaches TIMEOUT_MEM, mem_pronto wins and erro stays 0.
- Opcode is sampled in DECOD and held internally. Later IR changes do not alter the sequence.
- Register outputs not listed as asserted in a state are 0 in that state. This excludes the combinational enables noted above.
- Cycle counts with mem_pronto tied to 1:
  - R and addi: 4 cycles.
  - lw: 5 cycles.
  - sw, beq and j: 4, 3 and 3 cycles respectively.

Test Plan:
- Reset then mem_pronto=1, opcode=000000 -> states 0,1,2,3,5,1. In EXEC: origALU=0, opALU=10. In ESCRITA: escreveReg=1, regDst=1 for 1 cycle.
- opcode=100011 with mem_pronto low for 3 cycles in MEM -> leMem held 4 cycles, origALU=1, then ESCRITA with memParaReg=1, regDst=0.
- opcode=000100, zero=1, then again with zero=0 -> escrevePC=1, origPC=01 in EXEC for the first; escrevePC=0 for the second. Both return to BUSCA.
- mem_pronto held 0 in BUSCA with TIMEOUT_MEM=15 -> erro pulses at cycle 15 and again at cycle 30; state remains 1. mem_pronto coincident with cycle 15 -> erro=0, DECOD next.
- opcode=010101 -> erro=1 in DECOD for one cycle, next state BUSCA. opcode=111111 -> PARADO, all outputs 0 for 20 cycles.
- Assert reset mid-MEM on a sw with escreveMem=1 -> escreveMem drops to 0 in the same cycle (asynchronous) and state=0. After release: OCIOSO then BUSCA.
